serial_adder_ctrl: RTL and testbench

//  Sequences one shared 1-bit full_adder to add two WIDTH-bit operands bit-serially, LSB first.

---
 rtl/serial_adder_pkg.sv | 8 +
 rtl/serial_adder_ctrl.sv | 95 +++++++++
 tb/tb_serial_adder_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder sequencer.
package serial_adder_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sa_state_t;

  localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_ctrl.sv
// Sequences an external 1-bit full adder to add two WIDTH-bit operands LSB first,
// one bit pair per cycle, collecting the sum bits into a right-shifting register.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout_out,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  sa_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;

  // State, counter, operand/result shift registers and registered status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout_out <= 1'b0;
      cnt      <= '0;
      carry    <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh     <= op_a;
            b_sh     <= op_b;
            carry    <= cin_in;
            cnt      <= '0;
            sum      <= '0;
            cout_out <= 1'b0;
            busy     <= 1'b1;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
          sum   <= (sum >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
          carry <= fa_cout;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            cout_out <= fa_cout;
            done     <= 1'b1;
            state    <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Adder cell inputs are only live during RUN.
  always_comb begin
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    if (state == S_RUN) begin
      fa_a   = a_sh[0];
      fa_b   = b_sh[0];
      fa_cin = carry;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl with a behavioural full adder in the loop.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  // 8-bit instance
  logic         start;
  logic [W-1:0] op_a, op_b;
  logic         cin_in;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout_out;
  logic         fa_a, fa_b, fa_cin, fa_s, fa_cout;

  // 1-bit instance
  logic start1;
  logic op_a1, op_b1, cin1;
  logic busy1, done1;
  logic [0:0] sum1;
  logic cout1;
  logic fa_a1, fa_b1, fa_cin1, fa_s1, fa_cout1;

  assign fa_s     = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout  = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
  assign fa_s1    = fa_a1 ^ fa_b1 ^ fa_cin1;
  assign fa_cout1 = (fa_a1 & fa_b1) | (fa_a1 & fa_cin1) | (fa_b1 & fa_cin1);

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b), .cin_in(cin_in),
    .busy(busy), .done(done), .sum(sum), .cout_out(cout_out),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_s(fa_s), .fa_cout(fa_cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op_a(op_a1), .op_b(op_b1), .cin_in(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout_out(cout1),
    .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1), .fa_s(fa_s1), .fa_cout(fa_cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge, then count edges until done is seen (bounded).
  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        output int lat);
    @(negedge clk);
    op_a = a; op_b = b; cin_in = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, done, sum, cout_out, fa_a, fa_b, fa_cin} !== '0) begin
      tests_failed++;
      $display("FAIL reset_w8: got busy=%b done=%b sum=%h cout=%b fa=%b%b%b, want all 0",
               busy, done, sum, cout_out, fa_a, fa_b, fa_cin);
    end
    tests_run++;
    if ({busy1, done1, sum1, cout1, fa_a1, fa_b1, fa_cin1} !== '0) begin
      tests_failed++;
      $display("FAIL reset_w1: got busy=%b done=%b sum=%b cout=%b, want all 0",
               busy1, done1, sum1, cout1);
    end
    reset = 1'b0;
  endtask

  task automatic test_carry_ripple;
    int lat;
    @(negedge clk);
    op_a = 8'hFF; op_b = 8'h01; cin_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL ripple_busy: got %b want 1", busy);
    end
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    tests_run++;
    if (lat != W) begin
      tests_failed++;
      $display("FAIL ripple_latency: done after %0d edges, want %0d", lat, W);
    end
    tests_run++;
    if ({cout_out, sum} !== 9'h100) begin
      tests_failed++;
      $display("FAIL ripple_result: got %b_%h want 1_00", cout_out, sum);
    end
    @(posedge clk); #1;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ripple_pulse_end: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_carry_in;
    logic [W-1:0] a, b;
    a = 8'hA5; b = 8'h5A;
    @(negedge clk);
    op_a = a; op_b = b; cin_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++;
    if (fa_cin !== 1'b1) begin
      tests_failed++;
      $display("FAIL cin_run0: fa_cin got %b want 1", fa_cin);
    end
    for (int k = 0; k < int'(W); k++) begin
      tests_run++;
      if (fa_a !== a[k] || fa_b !== b[k]) begin
        tests_failed++;
        $display("FAIL cin_bits[%0d]: fa_a/fa_b got %b/%b want %b/%b", k, fa_a, fa_b, a[k], b[k]);
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (done !== 1'b1 || {cout_out, sum} !== 9'h100) begin
      tests_failed++;
      $display("FAIL cin_result: got done=%b %b_%h want done=1 1_00", done, cout_out, sum);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_while_busy;
    int dones;
    @(negedge clk);
    op_a = 8'h03; op_b = 8'h04; cin_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    op_a = 8'hFF; op_b = 8'hFF; cin_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        dones++;
        tests_run++;
        if ({cout_out, sum} !== 9'h007) begin
          tests_failed++;
          $display("FAIL busy_ignore_result: got %b_%h want 0_07", cout_out, sum);
        end
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (dones != 1) begin
      tests_failed++;
      $display("FAIL busy_ignore_dones: got %0d done pulses want 1", dones);
    end
  endtask

  task automatic test_reset_mid_run;
    int dones;
    int lat;
    @(negedge clk);
    op_a = 8'h7F; op_b = 8'h01; cin_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests_run++;
    if ({busy, done, sum, cout_out, fa_a, fa_b, fa_cin} !== '0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got busy=%b done=%b sum=%h cout=%b fa=%b%b%b want all 0",
               busy, done, sum, cout_out, fa_a, fa_b, fa_cin);
    end
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    tests_run++;
    if (dones != 0) begin
      tests_failed++;
      $display("FAIL midreset_no_done: got %0d done pulses want 0", dones);
    end
    do_add(8'h10, 8'h20, 1'b0, lat);
    tests_run++;
    if (lat != W || {cout_out, sum} !== 9'h030) begin
      tests_failed++;
      $display("FAIL midreset_restart: got lat=%0d %b_%h want lat=%0d 0_30", lat, cout_out, sum, W);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int last_done;
    int n_done;
    @(negedge clk);
    op_a = 8'h80; op_b = 8'h80; cin_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    last_done = -1;
    n_done = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (!busy || done) begin
        tests_run++;
        if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
          tests_failed++;
          $display("FAIL b2b_fa_idle[%0d]: fa=%b%b%b want 000", n, fa_a, fa_b, fa_cin);
        end
      end
      if (done) begin
        tests_run++;
        if ({cout_out, sum} !== 9'h100) begin
          tests_failed++;
          $display("FAIL b2b_result[%0d]: got %b_%h want 1_00", n, cout_out, sum);
        end
        tests_run++;
        if (last_done < 0 ? (n != int'(W)) : (n - last_done != int'(W) + 2)) begin
          tests_failed++;
          $display("FAIL b2b_spacing: done at edge %0d, previous %0d", n, last_done);
        end
        last_done = n;
        n_done++;
      end
    end
    start = 1'b0;
    tests_run++;
    if (n_done != 4) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d done pulses want 4", n_done);
    end
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_min_width;
    int lat;
    @(negedge clk);
    op_a1 = 1'b1; op_b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    tests_run++;
    if (lat != 1) begin
      tests_failed++;
      $display("FAIL w1_latency: done after %0d edges want 1", lat);
    end
    tests_run++;
    if ({cout1, sum1} !== 2'b11) begin
      tests_failed++;
      $display("FAIL w1_result: got %b%b want 11", cout1, sum1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [W-1:0] a, b;
    logic         c;
    logic [W:0]   exp;
    int           lat;
    for (int i = 0; i < 200; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      c = 1'($urandom);
      exp = {1'b0, a} + {1'b0, b} + (W+1)'(c);
      do_add(a, b, c, lat);
      tests_run++;
      if (lat != W || {cout_out, sum} !== exp) begin
        tests_failed++;
        $display("FAIL random[%0d] %h+%h+%b: got lat=%0d %h want lat=%0d %h",
                 i, a, b, c, lat, {cout_out, sum}, W, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    start = 1'b0; op_a = '0; op_b = '0; cin_in = 1'b0;
    start1 = 1'b0; op_a1 = 1'b0; op_b1 = 1'b0; cin1 = 1'b0;
    reset = 1'b1;
    test_reset();
    test_carry_ripple();
    test_carry_in();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    test_min_width();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
